// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers.
// Gray/binary helpers work on a 32-bit container, so any pointer width up to 32 can use them.
package fifo_wr_ctrl_pkg;

    localparam int FN_W          = 32;
    localparam int ADDRWIDTH_DEF = 3;
    localparam int DEPTH_DEF     = 1 << ADDRWIDTH_DEF;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs decode correctly because the leading zeros pass through unchanged
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Registered binary/Gray pointer with increment enable, shared by both FIFO sides.
// The Gray output comes straight from a flop, so it is safe to hand to a synchronizer.
module fifo_gray_ptr
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-2:0] addr,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_nxt,
    output logic [W-1:0] gray_nxt
);

    logic [W-1:0] bin;

    assign bin_nxt  = bin + {{(W-1){1'b0}}, inc};
    assign gray_nxt = W'(bin2gray(FN_W'(bin_nxt)));
    assign addr     = bin[W-2:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller for the dual-clock FIFO.
// Full, almost-full and count are computed against a lagging read pointer, so they err on the full side.
module fifo_wr_ctrl
    import fifo_wr_ctrl_pkg::*;
#(
    parameter int ADDRWIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we,
    input  logic [ADDRWIDTH:0]   rd_ptr_gray_sync,
    output logic [ADDRWIDTH:0]   wr_ptr_gray,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic                 mem_we,
    output logic                 full,
    output logic                 afull,
    output logic [ADDRWIDTH:0]   wr_cnt,
    output logic                 overflow
);

    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

    logic          wr_acc;
    logic [PW-1:0] wr_bin_nxt;
    logic [PW-1:0] wr_gray_nxt;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] full_gray;
    logic [PW-1:0] cnt_nxt;

    // full is the registered flag, so a same-cycle read cannot unblock a write
    assign wr_acc = we & ~full;
    assign mem_we = wr_acc;

    fifo_gray_ptr #(.W(PW)) u_wr_ptr (
        .clk      (clk),
        .rstn     (rstn),
        .inc      (wr_acc),
        .addr     (waddr),
        .gray     (wr_ptr_gray),
        .bin_nxt  (wr_bin_nxt),
        .gray_nxt (wr_gray_nxt)
    );

    assign rd_bin = PW'(gray2bin(FN_W'(rd_ptr_gray_sync)));

    // Writer is one full lap ahead: top two Gray bits inverted, remainder equal
    assign full_gray = {~rd_ptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1], rd_ptr_gray_sync[ADDRWIDTH-2:0]};
    assign cnt_nxt   = wr_bin_nxt - rd_bin;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full     <= 1'b0;
            afull    <= 1'b0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            full     <= (wr_gray_nxt == full_gray);
            afull    <= (cnt_nxt >= AFULL_T);
            wr_cnt   <= cnt_nxt;
            overflow <= we & full;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios then random writes/read advances,
// all compared against an occupancy model built from running write/read totals.
module tb_fifo_wr_ctrl;

    localparam int AW    = 3;
    localparam int D     = 1 << AW;
    localparam int THR   = 6;

    logic          clk;
    logic          rstn;
    logic          we;
    logic [AW:0]   rd_ptr_gray_sync;
    logic [AW:0]   wr_ptr_gray;
    logic [AW-1:0] waddr;
    logic          mem_we;
    logic          full;
    logic          afull;
    logic [AW:0]   wr_cnt;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    // Model state: total accepted writes and total reads seen, as plain integers
    int  wr_total = 0;
    int  rd_total = 0;
    bit  exp_full = 0;
    bit  exp_afull = 0;
    bit  exp_ovf = 0;

    fifo_wr_ctrl #(.ADDRWIDTH(AW), .AFULL_THRESH(THR)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .we               (we),
        .rd_ptr_gray_sync (rd_ptr_gray_sync),
        .wr_ptr_gray      (wr_ptr_gray),
        .waddr            (waddr),
        .mem_we           (mem_we),
        .full             (full),
        .afull            (afull),
        .wr_cnt           (wr_cnt),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW:0] to_gray(input int n);
        int b;
        b = n % (2 * D);
        return (AW+1)'(b ^ (b >> 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        check("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(wr_total)));
        check("wr_cnt",      32'(wr_cnt),      32'(wr_total - rd_total));
        check("full",        32'(full),        32'(exp_full));
        check("afull",       32'(afull),       32'(exp_afull));
        check("overflow",    32'(overflow),    32'(exp_ovf));
    endtask

    // One clock cycle: drive at negedge, check write-port outputs, clock, check registered flags
    task automatic step(input bit w, input int rd_new);
        bit acc;
        @(negedge clk);
        we               = w;
        rd_total         = rd_new;
        rd_ptr_gray_sync = to_gray(rd_total);
        #1;
        acc = w && !exp_full;
        check("mem_we", 32'(mem_we), 32'(acc));
        check("waddr",  32'(waddr),  32'(wr_total % D));
        @(posedge clk);
        exp_ovf = w && exp_full;
        if (acc) wr_total++;
        exp_full  = (wr_total - rd_total) == D;
        exp_afull = (wr_total - rd_total) >= THR;
        #1;
        check_regs();
    endtask

    task automatic model_reset();
        wr_total = 0; rd_total = 0;
        exp_full = 0; exp_afull = 0; exp_ovf = 0;
    endtask

    initial begin
        int room;
        int adv;
        we = 1'b0;
        rd_ptr_gray_sync = '0;
        rstn = 1'b0;
        #12;
        rstn = 1'b1;
        check_regs();

        // Some writes, then an asynchronous reset between clock edges
        for (int i = 0; i < 3; i++) step(1, 0);
        @(negedge clk);
        we = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("mem_we_rst", 32'(mem_we), 32'd0);
        #1;
        rstn = 1'b1;
        #0;
        check("mem_we_rel", 32'(mem_we), 32'd0);
        check("waddr_rel",  32'(waddr),  32'd0);
        check("gray_rel",   32'(wr_ptr_gray), 32'd0);

        // Fill from empty: gray 1,3,2,6,7,5,4,C; afull after 6th, full after 8th
        for (int i = 0; i < D; i++) step(1, 0);
        check("full_at_8",  32'(full),        32'd1);
        check("gray_at_8",  32'(wr_ptr_gray), 32'hC);

        // Writes while full: two overflow pulses, then clear
        step(1, 0);
        step(1, 0);
        check("ovf_2nd",   32'(overflow),    32'd1);
        step(0, 0);
        check("ovf_clear", 32'(overflow),    32'd0);

        // One read frees a slot; a single write refills it at address 0
        step(0, 1);
        check("cnt_after_rd", 32'(wr_cnt), 32'd7);
        step(1, 1);
        check("full_refill",  32'(full),   32'd1);

        // Drain and walk the pointers to wr=18, rd=15 for the wrap case
        step(0, 9);
        for (int i = 0; i < 8; i++) step(1, 9 + i);
        step(1, 15);
        check("wrap_cnt",   32'(wr_cnt), 32'd3);
        check("wrap_full",  32'(full),   32'd0);
        check("wrap_afull", 32'(afull),  32'd0);

        // Reach 8 outstanding with rd gray 0, then jump the read pointer by 4 during a write
        step(0, 16);
        for (int i = 0; i < 6; i++) step(1, 16);
        check("full_pre_jump", 32'(full), 32'd1);
        step(1, 20);
        check("cnt_jump",  32'(wr_cnt), 32'd4);
        check("full_jump", 32'(full),   32'd0);
        step(1, 20);
        check("cnt_jump_wr", 32'(wr_cnt), 32'd5);

        // Random writes and read-pointer advances; reads never overtake accepted writes
        for (int i = 0; i < 400; i++) begin
            room = wr_total - rd_total;
            adv  = 0;
            if (room > 0 && ($urandom % 3) == 0) begin
                adv = $urandom_range(1, (room < 4) ? room : 4);
            end
            step(($urandom % 4) != 0, rd_total + adv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
